mfu_accum: RTL

- Downstream stage of the mfu (multi-function precision-configurable multiplier).
- Consumes the packed 64-bit product word `o` plus its `mode`, unpacks it into per-lane unsigned products, and accumulates across beats of a tile.
- Emits one packed accumulator vector per tile over a valid/ready handshake.
- Feeds the sparse_dnn output/writeback path.

---
 rtl/sparse_dnn_pkg.sv | 22 ++
 rtl/mfu_unpack.sv | 34 +++
 rtl/mfu_accum.sv | 115 +++++++++++
 3 files changed

// File: rtl/sparse_dnn_pkg.sv
// rtl/sparse_dnn_pkg.sv - shared mode, lane-geometry and state definitions for the sparse_dnn mfu path
package sparse_dnn_pkg;

    localparam logic [2:0] MODE_2X2 = 3'b000;
    localparam logic [2:0] MODE_4X4 = 3'b001;
    localparam logic [2:0] MODE_8X8 = 3'b010;

    localparam int LANES_2X2 = 16;
    localparam int LANES_4X4 = 8;
    localparam int LANES_8X8 = 4;

    localparam int PW_2X2 = 4;
    localparam int PW_4X4 = 8;
    localparam int PW_8X8 = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/mfu_unpack.sv
// rtl/mfu_unpack.sv - splits a packed mfu product word into zero-extended per-lane products
module mfu_unpack
    import sparse_dnn_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int LANES = 16
) (
    input  logic [63:0]            o,
    input  logic [2:0]             mode,
    output logic [LANES*ACC_W-1:0] lanes,
    output logic                   mode_invalid
);

    always_comb begin
        lanes        = '0;
        mode_invalid = 1'b0;
        case (mode)
            MODE_2X2: begin
                for (int k = 0; k < LANES_2X2; k++)
                    lanes[k*ACC_W +: ACC_W] = {{(ACC_W-PW_2X2){1'b0}}, o[k*PW_2X2 +: PW_2X2]};
            end
            MODE_4X4: begin
                for (int k = 0; k < LANES_4X4; k++)
                    lanes[k*ACC_W +: ACC_W] = {{(ACC_W-PW_4X4){1'b0}}, o[k*PW_4X4 +: PW_4X4]};
            end
            MODE_8X8: begin
                for (int k = 0; k < LANES_8X8; k++)
                    lanes[k*ACC_W +: ACC_W] = {{(ACC_W-PW_8X8){1'b0}}, o[k*PW_8X8 +: PW_8X8]};
            end
            default: mode_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/mfu_accum.sv
// rtl/mfu_accum.sv - per-tile saturating lane accumulator behind the mfu multiplier
module mfu_accum
    import sparse_dnn_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int LANES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_o,
    input  logic [2:0]             in_mode,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] out_acc,
    output logic [2:0]             out_mode,
    output logic                   out_sat,
    output logic                   err_mode
);

    state_t                 state, state_n;
    logic [LANES*ACC_W-1:0] acc, lanes, sum;
    logic [2:0]             tile_mode;
    logic                   sat, err, mode_invalid, any_sat;
    logic                   accept, starting, bad, load, clear, add;

    mfu_unpack #(.ACC_W(ACC_W), .LANES(LANES)) u_unpack (
        .o            (in_o),
        .mode         (in_mode),
        .lanes        (lanes),
        .mode_invalid (mode_invalid)
    );

    assign in_ready  = (state != HOLD) || out_ready;
    assign accept    = in_valid && in_ready;
    // A beat accepted while releasing a result opens a new tile, just like IDLE.
    assign starting  = (state == IDLE) || (state == HOLD && out_ready);
    assign bad       = mode_invalid || (state == ACCUM && in_mode != tile_mode);
    assign out_valid = (state == HOLD);
    assign out_acc   = acc;
    assign out_mode  = tile_mode;
    assign out_sat   = sat;
    assign err_mode  = err;

    always_comb begin
        logic [ACC_W:0] s;
        sum     = '0;
        any_sat = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            s = {1'b0, acc[k*ACC_W +: ACC_W]} + {1'b0, lanes[k*ACC_W +: ACC_W]};
            if (s[ACC_W]) begin
                sum[k*ACC_W +: ACC_W] = '1;
                any_sat               = 1'b1;
            end else begin
                sum[k*ACC_W +: ACC_W] = s[ACC_W-1:0];
            end
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        clear   = 1'b0;
        add     = 1'b0;
        if (state == HOLD && out_ready)
            state_n = IDLE;
        if (accept) begin
            if (starting) begin
                load  = !bad;
                clear = bad;
                if (in_last)
                    state_n = HOLD;
                else
                    state_n = bad ? IDLE : ACCUM;
            end else begin
                add = !bad;
                if (in_last)
                    state_n = HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            tile_mode <= MODE_2X2;
            sat       <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (load) begin
                acc       <= lanes;
                tile_mode <= in_mode;
                sat       <= 1'b0;
            end else if (clear) begin
                acc <= '0;
                sat <= 1'b0;
            end else if (add) begin
                acc <= sum;
                sat <= sat | any_sat;
            end
            if (accept && bad)
                err <= 1'b1;
        end
    end

endmodule
